rolagem_matriz: RTL
===================

# rolagem_matriz

Horizontal-scroll frame generator that drives the 35 pixel inputs of the 7x5 matrix scanner. It accepts 7-pixel columns through a ready/valid handshake into a small column FIFO. At a fixed scroll rate it shifts the 5-column display window left by one column, inserting the FIFO head at the rightmost column. It sits directly upstream of the matrix scanner; its frame output is wired bit-for-bit to the scanner's pixel inputs.

## Interface

Parameters:
- `SHIFT_DIV`, default 25_000_000: clock cycles per scroll step; legal values are 2 or more.
- `FIFO_DEPTH`, default 8: column FIFO entries; must be a power of two, 2 or more.
- `BLANK_FILL`, default 0: when 1, a scroll tick with an empty FIFO shifts in an all-off column; when 0, the frame holds.

Ports:
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `limpar`  in  1  synchronous clear.
- `enable`  in  1  scroll enable; when 0, the tick counter is frozen.
- `col_data`  in  7  one column; bit r is the pixel in row r (row 0 is the top).
- `col_valid`  in  1  `col_data` is offered this cycle.
- `col_ready`  out  1  a column can be accepted this cycle; equals not-full.
- `quadro`  out  35  frame; bit `r*5+c` is the pixel at row r, column c (c=0 is column a, the leftmost; c=4 is column e).
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of columns stored in the FIFO.
- `ocioso`  out  1  FIFO is empty (`fifo_count == 0`).

## Operation

- Push: a column is accepted when `col_valid && col_ready` on a clock edge.
- `col_ready` is combinational from the registered `full` flag only. At FIFO_DEPTH entries, pushes are rejected even if a pop occurs in the same cycle.
- Tick counter:
  - counts 0..SHIFT_DIV-1 while `enable` is 1 and wraps to 0;
  - `tick` is asserted when `count == SHIFT_DIV-1 && enable`;
  - it holds its value while `enable` is 0.
- On a tick:
  - FIFO non-empty: for every row r, `quadro[r*5+c]` takes `quadro[r*5+c+1]` for c=0..3; column 4 takes the FIFO head; the head is popped.
  - FIFO empty, BLANK_FILL=1: the same shift, with column 4 set to 0.
  - FIFO empty, BLANK_FILL=0: no change.
- Simultaneous push and tick:
  - The tick decision uses the pre-edge FIFO state.
  - If the FIFO was empty, the pushed column is stored and is not shown until the next tick.
  - If the FIFO was non-empty, the push and the pop both occur and `fifo_count` is unchanged.
- `limpar` takes priority over everything:
  - next edge: `quadro`=0, FIFO emptied, counter=0;
  - any push in that cycle is dropped.
- Reset values (asynchronous, immediate):
  - `quadro`=0;
  - `fifo_count`=0;
  - `ocioso`=1;
  - `col_ready`=1;
  - tick counter=0, with FIFO pointers reset as well.
- Reset mid-scroll discards all stored columns and the frame; no partial state survives.

## Timing

- Every output except `col_ready` is registered.
- With `enable` held high, the first tick after reset occurs on the edge that ends cycle SHIFT_DIV-1. The frame changes on that edge.
- Minimum latency for a pushed column:
  - the column appears in column e on the first tick edge strictly after its push edge;
  - it reaches column a 4 ticks later.
- Throughput: at most one column is pushed per cycle and one is scrolled per SHIFT_DIV cycles.
- FIFO pointers wrap modulo FIFO_DEPTH. `fifo_count` never exceeds FIFO_DEPTH and never goes below 0.

## Structure

- Shared package `matriz_pkg`:
  - `LINHAS=7`, `COLUNAS=5`;
  - `PIXELS=35`;
  - the index function `pix(r,c)=r*COLUNAS+c`, also used when wiring to the scanner.
- Sub-module `fifo_colunas`:
  - 7-bit wide, FIFO_DEPTH deep, synchronous push/pop, first-word-fall-through head;
  - outputs `full`, `empty` and `count`;
  - has its own `limpar` input.
- The top level contains the tick counter, the shift register and the clear/priority logic.

## Test plan

Bench uses SHIFT_DIV=4, FIFO_DEPTH=8, `enable`=1.

1. Reset, then push columns 7'h7F, 7'h01, 7'h40, 7'h00, 7'h55 on consecutive cycles, then wait 5 ticks.
   - Required: column e shows 7'h7F after tick 1.
   - Required: after tick 5, column a = 7'h7F, column b = 7'h01, column c = 7'h40, column d = 7'h00, column e = 7'h55; `ocioso`=1.
2. Hold `col_valid` for 12 cycles with no tick in that window (`enable`=0).
   - Required: exactly 8 columns accepted; `col_ready`=0 from the 9th cycle; `fifo_count`=8.
3. With the FIFO full, raise `enable` so that a tick coincides with a new `col_valid`.
   - Required: the push is rejected; `fifo_count`=7 after the edge; `col_ready`=1 on the next cycle.
4. With an empty FIFO and BLANK_FILL=0, push 7'h2A on a tick edge.
   - Required: `quadro` is unchanged on that edge; 7'h2A appears in column e on the next tick.
   - Repeat with BLANK_FILL=1: required column e = 0 on the first tick and 7'h2A on the second.
5. Assert `limpar` while simultaneously pushing with 3 columns queued.
   - Required: `quadro`=0, `fifo_count`=0 and counter=0 after the edge; the pushed column is lost.
6. Assert `rst` asynchronously mid-cycle while the frame is non-zero.
   - Required: `quadro`=0, `ocioso`=1 and `col_ready`=1 before the next clock edge.
   - Required: after release, the first tick comes 4 cycles later.

Source files
------------

// File: rtl/matriz_pkg.sv
// rtl/matriz_pkg.sv - shared geometry and pixel indexing for the 7x5 matrix
// Purpose: row/column counts, frame and column types, and the pix(r,c)
//          index function that also defines the wiring into the scanner.
// Ports:   none (package).
package matriz_pkg;

  localparam int LINHAS  = 7;
  localparam int COLUNAS = 5;
  localparam int PIXELS  = LINHAS * COLUNAS;

  typedef logic [LINHAS-1:0] coluna_t;
  typedef logic [PIXELS-1:0] quadro_t;

  // Frame bit holding row r, column c (c=0 is the leftmost column).
  function automatic int pix(input int r, input int c);
    return r * COLUNAS + c;
  endfunction

endpackage

// File: rtl/rolagem_matriz_if.sv
// rtl/rolagem_matriz_if.sv - column stream handshake into the scroll generator
// Purpose: groups the column data/valid/ready handshake.
// Ports:   col_data (7, row r in bit r), col_valid (source), col_ready (sink).
interface rolagem_matriz_if import matriz_pkg::*; ();

  coluna_t col_data;
  logic    col_valid;
  logic    col_ready;

  modport master (output col_data, output col_valid, input  col_ready);
  modport slave  (input  col_data, input  col_valid, output col_ready);

endinterface

// File: rtl/rolagem_matriz_fifo.sv
// rtl/rolagem_matriz_fifo.sv - column FIFO with first-word-fall-through head
// Purpose: FIFO_DEPTH x 7-bit column store; push/pop on the rising edge.
// Ports:   clk, rst (async, active high), limpar (sync clear), push, pop,
//          din (column in), head (oldest column), full, empty, count.
module fifo_colunas import matriz_pkg::*; #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        limpar,
  input  logic                        push,
  input  logic                        pop,
  input  coluna_t                     din,
  output coluna_t                     head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);

  coluna_t       mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_next;
  logic          do_push;
  logic          do_pop;

  // Requests are masked here too, so the FIFO protects itself even if the
  // caller forgets to gate on full/empty.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + 1'b1;
    else if (do_pop && !do_push)
      count_next = count - 1'b1;
  end

  // Flags are registered from the next count so col_ready has no path
  // back through the push/pop decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (limpar) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == DEPTH_V);
      empty <= (count_next == '0);
    end
  end

  // Storage needs no reset: it is only readable through a valid count.
  always_ff @(posedge clk) begin
    if (do_push && !limpar)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rolagem_matriz.sv
// rtl/rolagem_matriz.sv - horizontal-scroll frame generator for the 7x5 matrix
// Purpose: queues incoming columns and, every SHIFT_DIV enabled cycles,
//          shifts the 5-column window left, inserting the FIFO head at the
//          right (column e).
// Ports:   clk, rst (async, active high), limpar (sync clear), enable,
//          col_if (column stream, slave side), quadro (35-bit frame,
//          bit pix(r,c)), fifo_count, ocioso (FIFO empty).
module rolagem_matriz import matriz_pkg::*; #(
  parameter int SHIFT_DIV  = 25_000_000,
  parameter int FIFO_DEPTH = 8,
  parameter int BLANK_FILL = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        limpar,
  input  logic                        enable,
  rolagem_matriz_if.slave             col_if,
  output quadro_t                     quadro,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        ocioso
);

  localparam int            CW      = $clog2(SHIFT_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SHIFT_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tick;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          shift;
  coluna_t       head;
  coluna_t       new_col;
  quadro_t       quadro_next;

  assign tick = enable && (cnt == CNT_MAX);

  // Ready depends only on the registered full flag, so a pop in the same
  // cycle never opens room for a push.
  assign col_if.col_ready = !full;
  assign push = col_if.col_valid && !full && !limpar;
  assign pop  = tick && !empty && !limpar;

  // Empty FIFO on a tick: shift in a blank column or hold the frame.
  assign shift   = tick && (!empty || (BLANK_FILL != 0));
  assign new_col = empty ? '0 : head;

  fifo_colunas #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .limpar (limpar),
    .push   (push),
    .pop    (pop),
    .din    (col_if.col_data),
    .head   (head),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count)
  );

  assign ocioso = empty;

  always_comb begin
    quadro_next = quadro;
    if (shift) begin
      for (int r = 0; r < LINHAS; r++) begin
        for (int c = 0; c < COLUNAS-1; c++)
          quadro_next[pix(r, c)] = quadro[pix(r, c+1)];
        quadro_next[pix(r, COLUNAS-1)] = new_col[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      quadro <= '0;
    end else if (limpar) begin
      cnt    <= '0;
      quadro <= '0;
    end else begin
      if (enable)
        cnt <= tick ? '0 : cnt + 1'b1;
      quadro <= quadro_next;
    end
  end

endmodule
